// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE 754 binary32 divider, restoring radix-2, one quotient bit per clock.
// Optional feature macro FP_DIV_RNE_EN: round-to-nearest-even when defined, truncation otherwise.

module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] flp_a,
  input  logic [31:0] flp_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

`ifdef FP_DIV_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [4:0]  LAST_ITER = 5'd25;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV   = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic [31:0]        a_r, b_r;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        mb_r;
  logic [24:0]        rem_r;
  logic [25:0]        q_r;
  logic [4:0]         cnt_r;
  logic               busy_r, done_r;
  logic [31:0]        result_r;
  logic               invalid_r, div_by_zero_r, overflow_r, underflow_r;

  // Operand unpacking; exponent 0 is treated as zero so denormals flush.
  logic              sa_s, sb_s, sign_s;
  logic [7:0]        ea_s, eb_s;
  logic [22:0]       fa_s, fb_s;
  logic              a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
  logic signed [9:0] exp_calc_s;

  assign sa_s       = a_r[31];
  assign sb_s       = b_r[31];
  assign ea_s       = a_r[30:23];
  assign eb_s       = b_r[30:23];
  assign fa_s       = a_r[22:0];
  assign fb_s       = b_r[22:0];
  assign sign_s     = sa_s ^ sb_s;
  assign a_zero_s   = (ea_s == 8'd0);
  assign b_zero_s   = (eb_s == 8'd0);
  assign a_inf_s    = (ea_s == 8'hFF) && (fa_s == 23'd0);
  assign b_inf_s    = (eb_s == 8'hFF) && (fb_s == 23'd0);
  assign a_nan_s    = (ea_s == 8'hFF) && (fa_s != 23'd0);
  assign b_nan_s    = (eb_s == 8'hFF) && (fb_s != 23'd0);
  assign exp_calc_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;

  logic        special_s, spec_inv_s, spec_dbz_s;
  logic [31:0] spec_result_s;

  // Special-operand classification, in priority order.
  always_comb begin
    special_s     = 1'b1;
    spec_result_s = 32'd0;
    spec_inv_s    = 1'b0;
    spec_dbz_s    = 1'b0;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_result_s = QNAN;
      spec_inv_s    = 1'b1;
    end else if (a_inf_s) begin
      spec_result_s = {sign_s, 8'hFF, 23'd0};
    end else if (b_zero_s) begin
      spec_result_s = {sign_s, 8'hFF, 23'd0};
      spec_dbz_s    = 1'b1;
    end else if (a_zero_s || b_inf_s) begin
      spec_result_s = {sign_s, 31'd0};
    end else begin
      special_s     = 1'b0;
    end
  end

  // One restoring-division step: keep the trial difference when it is non-negative.
  logic [25:0] trial_s;
  logic        q_bit_s;
  logic [24:0] rem_keep_s;

  assign trial_s    = {1'b0, rem_r} - {2'b00, mb_r};
  assign q_bit_s    = ~trial_s[25];
  assign rem_keep_s = q_bit_s ? trial_s[24:0] : rem_r;

  logic [22:0]       mant_s, mant_rnd_s;
  logic              guard_s, sticky_s, round_inc_s, carry_s;
  logic signed [9:0] e_norm_s, e_fin_s;
  logic [31:0]       round_result_s;
  logic              round_ovf_s, round_unf_s;

  // Normalize, round and range-check the finished quotient.
  always_comb begin
    mant_s         = 23'd0;
    guard_s        = 1'b0;
    sticky_s       = 1'b0;
    e_norm_s       = exp_r;
    round_result_s = 32'd0;
    round_ovf_s    = 1'b0;
    round_unf_s    = 1'b0;
    if (q_r[25]) begin
      mant_s   = q_r[24:2];
      guard_s  = q_r[1];
      sticky_s = q_r[0] | (rem_r != 25'd0);
      e_norm_s = exp_r;
    end else begin
      mant_s   = q_r[23:1];
      guard_s  = q_r[0];
      sticky_s = (rem_r != 25'd0);
      e_norm_s = exp_r - 10'sd1;
    end
    round_inc_s           = RNE_EN & guard_s & (sticky_s | mant_s[0]);
    {carry_s, mant_rnd_s} = {1'b0, mant_s} + {23'd0, round_inc_s};
    e_fin_s               = carry_s ? (e_norm_s + 10'sd1) : e_norm_s;
    if (e_fin_s >= 10'sd255) begin
      round_result_s = {sign_r, 8'hFF, 23'd0};
      round_ovf_s    = 1'b1;
    end else if (e_fin_s <= 10'sd0) begin
      round_result_s = {sign_r, 31'd0};
      round_unf_s    = 1'b1;
    end else begin
      round_result_s = {sign_r, e_fin_s[7:0], mant_rnd_s};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CHECK;
        else       state_s = IDLE;
      end
      CHECK: begin
        if (special_s) state_s = DONE;
        else           state_s = DIV;
      end
      DIV: begin
        if (cnt_r == LAST_ITER) state_s = ROUND;
        else                    state_s = DIV;
      end
      ROUND:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r           <= 32'd0;
      b_r           <= 32'd0;
      sign_r        <= 1'b0;
      exp_r         <= 10'sd0;
      mb_r          <= 24'd0;
      rem_r         <= 25'd0;
      q_r           <= 26'd0;
      cnt_r         <= 5'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      result_r      <= 32'd0;
      invalid_r     <= 1'b0;
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r           <= flp_a;
            b_r           <= flp_b;
            busy_r        <= 1'b1;
            invalid_r     <= 1'b0;
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
          end
        end
        CHECK: begin
          sign_r <= sign_s;
          if (special_s) begin
            result_r      <= spec_result_s;
            invalid_r     <= spec_inv_s;
            div_by_zero_r <= spec_dbz_s;
            done_r        <= 1'b1;
          end else begin
            exp_r <= exp_calc_s;
            mb_r  <= {1'b1, fb_s};
            rem_r <= {1'b0, 1'b1, fa_s};
            q_r   <= 26'd0;
            cnt_r <= 5'd0;
          end
        end
        DIV: begin
          rem_r <= rem_keep_s << 1'b1;
          q_r   <= {q_r[24:0], q_bit_s};
          cnt_r <= cnt_r + 5'd1;
        end
        ROUND: begin
          result_r    <= round_result_s;
          overflow_r  <= round_ovf_s;
          underflow_r <= round_unf_s;
          done_r      <= 1'b1;
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign invalid     = invalid_r;
  assign div_by_zero = div_by_zero_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed table-driven bench for fp_div_seq plus hand-written handshake,
// re-start and mid-operation reset sequences. Honors FP_DIV_RNE_EN for the rounding-dependent values.

module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] flp_a, flp_b;
  logic        busy, done, invalid, div_by_zero, overflow, underflow;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] ONE_THIRD  = 32'h3EAA_AAAB;
  localparam logic [31:0] TWO_THIRDS = 32'h3F2A_AAAB;
`else
  localparam logic [31:0] ONE_THIRD  = 32'h3EAA_AAAA;
  localparam logic [31:0] TWO_THIRDS = 32'h3F2A_AAAA;
`endif

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .flp_a       (flp_a),
    .flp_b       (flp_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .invalid     (invalid),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;   // {invalid, div_by_zero, overflow, underflow}
    int          lat;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'd0, invalid, div_by_zero, overflow, underflow};
  endfunction

  // Launch one op and wait (bounded) for done; optionally pulse start with other operands at edge inj_edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_edge,
                        input logic [31:0] inj_a, input logic [31:0] inj_b, output int lat);
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    flp_a = a;
    flp_b = b;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      start = (k == inj_edge);
      flp_a = (k == inj_edge) ? inj_a : ~a;
      flp_b = (k == inj_edge) ? inj_b : ~b;
      @(posedge clk);
      @(negedge clk);
      chk("busy during op", {31'd0, busy}, 32'd1);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int done_seen;

    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28};
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, ONE_THIRD,     4'b0000, 28};
    vecs[2]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 1};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1};
    vecs[4]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 28};
    vecs[5]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 28};
    vecs[6]  = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1};
    vecs[7]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, 1};
    vecs[8]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1};
    vecs[9]  = '{32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 1};
    vecs[10] = '{32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 4'b0000, 1};
    vecs[11] = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 1};
    vecs[12] = '{32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 4'b0000, 28};
    vecs[13] = '{32'h3F80_0000, 32'h3F80_0001, 32'h3F7F_FFFE, 4'b0000, 28};
    vecs[14] = '{32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'b0000, 28};
    vecs[15] = '{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 4'b0000, 28};
    vecs[16] = '{32'h4000_0000, 32'h4040_0000, TWO_THIRDS,    4'b0000, 28};
    vecs[17] = '{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 4'b0100, 1};

    rst_n = 1'b0;
    start = 1'b0;
    flp_a = 32'd0;
    flp_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset busy",   {31'd0, busy}, 32'd0);
    chk("reset done",   {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset flags",  flags_now(), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 32'd0, 32'd0, lat);
      chk($sformatf("vec%0d result", i),  result, vecs[i].res);
      chk($sformatf("vec%0d flags", i),   flags_now(), {28'd0, vecs[i].flags});
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d busy drop", i),  {31'd0, busy}, 32'd0);
      chk($sformatf("vec%0d held", i),       result, vecs[i].res);
    end

    // start re-pulsed at edge 10 with other operands must be ignored.
    run_op(32'h40C0_0000, 32'h4000_0000, 10, 32'h3F80_0000, 32'h4040_0000, lat);
    chk("restart latency", lat, 28);
    chk("restart result",  result, 32'h4040_0000);

    // start held through the DONE cycle is taken on the following edge only.
    start = 1'b1;
    flp_a = 32'h4000_0000;
    flp_b = 32'h4040_0000;
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle busy", {31'd0, busy}, 32'd0);
    chk("b2b idle done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b accepted busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("b2b latency", lat, 28);
    chk("b2b result",  result, TWO_THIRDS);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of DIV discards the op.
    start = 1'b1;
    flp_a = 32'h3F80_0000;
    flp_b = 32'h4040_0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy",   {31'd0, busy}, 32'd0);
    chk("midrst done",   {31'd0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (35) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst no done", done_seen, 0);
    chk("midrst idle",    {31'd0, busy}, 32'd0);

    run_op(32'h40C0_0000, 32'h4000_0000, 0, 32'd0, 32'd0, lat);
    chk("post-reset latency", lat, 28);
    chk("post-reset result",  result, 32'h4040_0000);
    chk("post-reset flags",   flags_now(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
